pulse_limiter: RTL
==================

# pulse_limiter

Safety conditioner for the interrupter pulse between the 5V-TTL input pin and the serial transmitter's raw-pulse input. It synchronizes and glitch-filters the asynchronous pulse, then passes it through a state machine that caps each pulse's on-time and enforces a minimum off-time. This guarantees the link never carries a stuck-high or over-long gate command. Cut-off events are flagged and counted for LEDs and debug.

## Interface

Parameters:
- FILT_CYC, 6, glitch-filter length in clocks; 100 ns at 60 MHz.
- MAX_ON_UNIT, 1200, on-time limit step in clocks; 20 us.
- MIN_OFF_CYC, 3000, minimum off-time in clocks; 50 us.
- CNT_W, 16, width of the on and off counters; must hold 8*MAX_ON_UNIT and MIN_OFF_CYC.

Ports:
- i_clk  input  1  60 MHz system clock.
- i_res  input  1  reset; synchronous, active-high.
- i_pls  input  1  raw interrupter pulse, asynchronous.
- i_enable  input  1  0 forces the output off.
- i_sel  input  3  on-time limit select; max_on = MAX_ON_UNIT*(i_sel+1).
- o_pls  output  1  limited pulse, registered.
- o_trip  output  1  one-cycle strobe when the on-time limit cuts a pulse.
- o_trip_cnt  output  8  trip count, saturates at 255.
- o_state  output  2  FSM state: 0 IDLE, 1 ON, 2 LOCKOUT, 3 HOLDOFF.

## Operation

Synchronizer and filter:
- i_pls passes through two flops, s1 then s2.
- Filter register f and counter fc:
  - s2==f: fc<=0.
  - s2!=f and fc==FILT_CYC-1: f<=s2, fc<=0.
  - otherwise fc<=fc+1.
- A level must persist FILT_CYC consecutive cycles at s2 to reach f.
- f_d is f delayed one cycle. rise = f & ~f_d.

FSM, all registered:
- IDLE: o_pls=0. On rise & i_enable: go to ON, on_cnt<=0, latch max_on from i_sel. f already high at IDLE entry without a rise is ignored.
- ON: o_pls=1, on_cnt increments. Priority order:
  1. ~f or ~i_enable: go to HOLDOFF, off_cnt<=0.
  2. on_cnt==max_on-1: go to LOCKOUT, o_trip=1 for one cycle, o_trip_cnt increments unless it is 255.
- LOCKOUT: o_pls=0. Wait for ~f, then go to HOLDOFF with off_cnt<=0.
- HOLDOFF: o_pls=0, off_cnt increments. At off_cnt==MIN_OFF_CYC-1, go to IDLE. Input rises during HOLDOFF are dropped, not deferred.

Width and arithmetic rules:
- max_on is computed in CNT_W bits.
- i_sel changes mid-pulse have no effect.

Reset:
- s1, s2, f, f_d, fc, counters = 0.
- state = IDLE, o_pls = 0, o_trip = 0, o_trip_cnt = 0.
- Reset during ON drops o_pls on the next edge.

## Timing

- Latency i_pls rise to o_pls rise: FILT_CYC+3 edges, counting the first edge that samples i_pls high; 9 clocks, 150 ns at defaults. Fall latency is the same.
- Pulses shorter than FILT_CYC clocks at s2 are suppressed entirely.
- Output pulse width = input width (±1 clk of sync jitter), capped at exactly max_on clocks.
- Off time after any pulse: at least MIN_OFF_CYC+1 clocks from o_pls fall to the earliest next o_pls rise.
- Simultaneous ~f and limit reached in ON: ~f wins. No trip, go to HOLDOFF.
- i_enable deasserted in IDLE blocks starts. In ON it ends the pulse in HOLDOFF without a trip.
- o_trip is asserted on the same cycle that o_pls first reads 0 after a cut.

## Test plan

- 10 us input pulse, i_sel=0, enable=1: o_pls high 600±1 clk, delayed 9 clk. o_trip stays 0, state returns to IDLE 3001 clk after fall.
- 5-clk glitch on i_pls: o_pls stays 0, f never changes. A 6-clk pulse produces a 6±1 clk o_pls.
- Input held high 1 ms, i_sel=0: o_pls exactly 1200 clk. o_trip is 1 for one cycle and o_trip_cnt=1. State stays LOCKOUT until input falls, then HOLDOFF, then IDLE; there is no second pulse.
- i_sel=7, held input: o_pls width 9600 clk. Changing i_sel to 0 mid-pulse does not shorten it.
- Second pulse starting 20 us after the first ends: it is dropped and o_pls stays 0. A pulse 60 us after the first ends passes.
- Assert i_res in ON: o_pls=0 next edge, all outputs zero. 300 forced trips leave o_trip_cnt saturated at 255.

Source files
------------

// File: rtl/pulse_limiter.sv
// Interrupter pulse conditioner: sync + glitch filter, then an FSM that caps
// on-time, enforces a minimum off-time and counts on-time cut-offs.
module pulse_limiter #(
    parameter int FILT_CYC    = 6,
    parameter int MAX_ON_UNIT = 1200,
    parameter int MIN_OFF_CYC = 3000,
    parameter int CNT_W       = 16
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_pls,
    input  logic       i_enable,
    input  logic [2:0] i_sel,
    output logic       o_pls,
    output logic       o_trip,
    output logic [7:0] o_trip_cnt,
    output logic [1:0] o_state
);
    localparam int FC_W = ($clog2(FILT_CYC) > 0) ? $clog2(FILT_CYC) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ON      = 2'd1,
        LOCKOUT = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    logic            s1, s2, f, f_d, rise;
    logic [FC_W-1:0] fc;
    state_t          state, state_nxt;
    logic [CNT_W-1:0] on_cnt, off_cnt, max_on, max_on_sel;
    logic            pls_nxt, trip_nxt, on_last, off_last;

    // A level change reaches f only after FILT_CYC consecutive cycles at s2.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            f   <= 1'b0;
            f_d <= 1'b0;
            fc  <= '0;
        end else begin
            s1  <= i_pls;
            s2  <= s1;
            f_d <= f;
            if (s2 == f) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                f  <= s2;
                fc <= '0;
            end else begin
                fc <= fc + FC_W'(1);
            end
        end
    end

    assign rise       = f & ~f_d;
    assign max_on_sel = CNT_W'(MAX_ON_UNIT) * (CNT_W'(i_sel) + CNT_W'(1));
    assign on_last    = (on_cnt == max_on - CNT_W'(1));
    assign off_last   = (off_cnt == OFF_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise && i_enable) state_nxt = ON;
            ON: begin
                // Input fall or disable outranks the limit: no trip in that case.
                if (!f || !i_enable) state_nxt = HOLDOFF;
                else if (on_last)    state_nxt = LOCKOUT;
            end
            LOCKOUT: if (!f)      state_nxt = HOLDOFF;
            HOLDOFF: if (off_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pls_nxt  = (state_nxt == ON);
        trip_nxt = (state == ON) && (state_nxt == LOCKOUT);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state      <= IDLE;
            on_cnt     <= '0;
            off_cnt    <= '0;
            max_on     <= '0;
            o_pls      <= 1'b0;
            o_trip     <= 1'b0;
            o_trip_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            o_pls  <= pls_nxt;
            o_trip <= trip_nxt;
            if (trip_nxt && o_trip_cnt != 8'hFF)
                o_trip_cnt <= o_trip_cnt + 8'd1;
            // Limit is frozen at pulse start so i_sel changes mid-pulse are ignored.
            if (state == IDLE && state_nxt == ON) begin
                on_cnt <= '0;
                max_on <= max_on_sel;
            end else if (state == ON) begin
                on_cnt <= on_cnt + CNT_W'(1);
            end
            if (state != HOLDOFF && state_nxt == HOLDOFF)
                off_cnt <= '0;
            else if (state == HOLDOFF)
                off_cnt <= off_cnt + CNT_W'(1);
        end
    end

    assign o_state = state;
endmodule
